// File: rtl/spectro_pkg.sv
// Shared definitions for the spectrogram serial readout stage.
// Holds the readout FSM state encoding and the default array geometry
// (word width, bins per frame, frames stored) used by spectro_serial_tx.
package spectro_pkg;

    localparam int DEF_WORD_W     = 8;
    localparam int DEF_NUM_BINS   = 4;
    localparam int DEF_NUM_FRAMES = 8;
    localparam int PAIRS_PER_WORD = DEF_WORD_W / 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/spectro_serial_tx.sv
// Drains the memorized time x bin word array over a 2-bit serial link.
// Words are read in address order (addr = frame*NUM_BINS + bin) and shifted
// out MSB pair first, one pair per readout tick.
//
// Ports:
//   input_acquisition_clk  single clock, rising edge
//   reset                  asynchronous, active-high
//   start                  1-cycle readout request (honoured only in IDLE with mem_valid)
//   abort                  synchronous abort back to IDLE, no done pulse
//   mem_valid              memorization-completed level from the memory stage
//   readout_tick           1-cycle strobe per serial clock edge (>= 4 clocks apart)
//   rd_en / rd_addr        memory read request; rd_data is valid the cycle after rd_en
//   serial_out             current bit pair
//   sl_time                marks the first pair of bin 0 of every frame
//   sl_ch                  marks the first pair of every word
//   sending_data           high from the first emitted pair until readout end
//   done                   1-cycle pulse at readout end
//   fsm_state              current FSM state, for observation
//
// Memory handshake: rd_en is a single-cycle request carrying rd_addr; there is
// no backpressure, and the word on rd_data is captured exactly one cycle later.
module spectro_serial_tx
    import spectro_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int NUM_BINS   = DEF_NUM_BINS,
    parameter int NUM_FRAMES = DEF_NUM_FRAMES,
    parameter int ADDR_W     = $clog2(NUM_BINS * NUM_FRAMES)
) (
    input  logic              input_acquisition_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              mem_valid,
    input  logic              readout_tick,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic [1:0]        serial_out,
    output logic              sl_time,
    output logic              sl_ch,
    output logic              sending_data,
    output logic              done,
    output state_t            fsm_state
);

    localparam int PAIRS     = WORD_W / 2;
    localparam int CNT_W     = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int LAST_ADDR = NUM_BINS * NUM_FRAMES - 1;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [WORD_W-1:0]   shreg;
    logic [CNT_W-1:0]    pair_cnt;
    logic                pending;

    logic first_bin;
    logic last_pair;
    logic last_addr;
    logic fire;

    // Bin index is addr modulo NUM_BINS; no separate bin/frame counters.
    assign first_bin = ((32'(addr) % NUM_BINS) == 0);
    assign last_pair = (pair_cnt == CNT_W'(PAIRS - 1));
    assign last_addr = (addr == ADDR_W'(LAST_ADDR));
    // A tick that landed in FETCH/LOAD is replayed on the first SHIFT cycle.
    assign fire      = readout_tick | pending;

    assign rd_addr   = addr;
    assign fsm_state = state;

    always_ff @(posedge input_acquisition_clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= '0;
            shreg        <= '0;
            pair_cnt     <= '0;
            pending      <= 1'b0;
            rd_en        <= 1'b0;
            serial_out   <= 2'b00;
            sl_time      <= 1'b0;
            sl_ch        <= 1'b0;
            sending_data <= 1'b0;
            done         <= 1'b0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            if (abort && state != IDLE) begin
                // Abort wins over a same-cycle tick and suppresses done.
                state        <= IDLE;
                addr         <= '0;
                pair_cnt     <= '0;
                pending      <= 1'b0;
                serial_out   <= 2'b00;
                sl_time      <= 1'b0;
                sl_ch        <= 1'b0;
                sending_data <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && mem_valid) begin
                            addr  <= '0;
                            rd_en <= 1'b1;
                            state <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (readout_tick) pending <= 1'b1;
                        state <= LOAD;
                    end
                    LOAD: begin
                        // A second tick while pending is already set is dropped.
                        if (readout_tick) pending <= 1'b1;
                        shreg    <= rd_data;
                        pair_cnt <= '0;
                        state    <= SHIFT;
                    end
                    SHIFT: begin
                        if (fire) begin
                            pending      <= 1'b0;
                            serial_out   <= shreg[WORD_W-1 -: 2];
                            shreg        <= shreg << 2;
                            sl_ch        <= (pair_cnt == '0);
                            sl_time      <= (pair_cnt == '0) && first_bin;
                            sending_data <= 1'b1;
                            pair_cnt     <= pair_cnt + 1'b1;
                            if (last_pair) begin
                                if (last_addr) begin
                                    state <= DRAIN;
                                end else begin
                                    addr  <= addr + 1'b1;
                                    rd_en <= 1'b1;
                                    state <= FETCH;
                                end
                            end
                        end
                    end
                    DRAIN: begin
                        if (readout_tick) begin
                            serial_out   <= 2'b00;
                            sl_time      <= 1'b0;
                            sl_ch        <= 1'b0;
                            sending_data <= 1'b0;
                            done         <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spectro_serial_tx.sv
// Bench for spectro_serial_tx with a 2 x 2 word array of 8-bit words.
// The expected link traffic is built from the memory contents by plain
// arithmetic; pair timing follows the tick/pending latency rules.
module tb_spectro_serial_tx;
    import spectro_pkg::*;

    localparam int W      = 8;
    localparam int NB     = 2;
    localparam int NF     = 2;
    localparam int AW     = 2;
    localparam int NW     = NB * NF;
    localparam int PAIRS  = W / 2;
    localparam int NPAIRS = NW * PAIRS;

    // clock / reset
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          start, abort, mem_valid, readout_tick;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic [1:0]    serial_out;
    logic          sl_time, sl_ch, sending_data, done;
    state_t        fsm_state;

    spectro_serial_tx #(
        .WORD_W(W), .NUM_BINS(NB), .NUM_FRAMES(NF), .ADDR_W(AW)
    ) dut (
        .input_acquisition_clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .mem_valid(mem_valid),
        .readout_tick(readout_tick),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .serial_out(serial_out),
        .sl_time(sl_time),
        .sl_ch(sl_ch),
        .sending_data(sending_data),
        .done(done),
        .fsm_state(fsm_state)
    );

    // memory model: word available the cycle after rd_en
    logic [W-1:0] mem [NW];
    initial rd_data = '0;
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // scoreboard
    logic [3:0] exp_q[$];   // {sl_time, sl_ch, pair}
    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;
    int exp_addr = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int exp_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rd_en) begin
            check("rd_addr", 32'(rd_addr), 32'(exp_addr));
            exp_addr++;
            rd_cnt++;
        end
        if (done) done_cnt++;
    end

    // reference model: whole readout stream derived from the memory image
    function automatic void build_model();
        int v;
        logic [1:0] pair;
        logic ch, tm;
        exp_q.delete();
        for (int w = 0; w < NW; w++) begin
            for (int p = 0; p < PAIRS; p++) begin
                v    = int'(mem[w]);
                pair = 2'((v / (1 << (W - 2 - 2 * p))) % 4);
                ch   = (p == 0);
                tm   = (p == 0) && ((w % NB) == 0);
                exp_q.push_back({tm, ch, pair});
            end
        end
    endfunction

    // driver: one clock edge, inputs applied from the preceding negedge
    task automatic cycle(input logic t, input logic s, input logic a);
        readout_tick = t;
        start        = s;
        abort        = a;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        readout_tick = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
    endtask

    task automatic idle_until(input int e, input bit noise);
        while (edge_n < e) cycle(1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_serial"}, 32'(serial_out), 32'd0);
        check({tag, "_sl_ch"}, 32'(sl_ch), 32'd0);
        check({tag, "_sl_time"}, 32'(sl_time), 32'd0);
        check({tag, "_sending"}, 32'(sending_data), 32'd0);
    endtask

    task automatic run_readout(input int first_off, input int gmin, input int gmax,
                               input bit noise, input bit mv_drop,
                               input int abort_i, input int reset_i);
        logic [3:0] e;
        int prev_t, t, emit, ready;
        build_model();
        exp_addr  = 0;
        mem_valid = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        if (mv_drop) mem_valid = 1'b0;
        ready  = edge_n + 3;
        prev_t = edge_n;
        for (int i = 0; i <= NPAIRS; i++) begin
            t = prev_t + ((i == 0) ? first_off : int'($urandom_range(gmin, gmax)));
            idle_until(t - 1, noise);
            cycle(1'b1, 1'b0, 1'b0);
            prev_t = t;
            if (i < NPAIRS) begin
                emit = (t > ready) ? t : ready;
                idle_until(emit, noise);
                e = exp_q.pop_front();
                check("pair", 32'(serial_out), 32'(e[1:0]));
                check("sl_ch", 32'(sl_ch), 32'(e[2]));
                check("sl_time", 32'(sl_time), 32'(e[3]));
                check("sending", 32'(sending_data), 32'd1);
                check("done_early", 32'(done), 32'd0);
                ready = emit + (((i % PAIRS) == PAIRS - 1) ? 3 : 1);
                if (i == abort_i) begin
                    idle_until(t + 3, 1'b0);
                    cycle(1'b1, 1'b0, 1'b1);
                    check_quiet("abort");
                    check("abort_done", 32'(done), 32'd0);
                    check("abort_rd_en", 32'(rd_en), 32'd0);
                    check("abort_state", 32'(fsm_state), 32'(IDLE));
                    repeat (2) begin
                        repeat (5) cycle(1'b0, 1'b0, 1'b0);
                        cycle(1'b1, 1'b0, 1'b0);
                    end
                    check_quiet("post_abort");
                    return;
                end
                if (i == reset_i) begin
                    #2 reset = 1'b1;
                    #1;
                    check_quiet("async_rst");
                    check("async_rst_rd_en", 32'(rd_en), 32'd0);
                    check("async_rst_state", 32'(fsm_state), 32'(IDLE));
                    @(posedge clk);
                    edge_n++;
                    @(negedge clk);
                    reset = 1'b0;
                    return;
                end
            end else begin
                check_quiet("drain");
                check("done_pulse", 32'(done), 32'd1);
                exp_done++;
                cycle(1'b0, 1'b0, 1'b0);
                check("done_clear", 32'(done), 32'd0);
                check("end_state", 32'(fsm_state), 32'(IDLE));
            end
        end
    endtask

    task automatic load_fixed();
        mem[0] = 8'hB4; mem[1] = 8'h0F; mem[2] = 8'hC3; mem[3] = 8'h55;
    endtask

    task automatic load_random();
        for (int k = 0; k < NW; k++) mem[k] = W'($urandom_range(0, 255));
    endtask

    initial begin
        int rd0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; mem_valid = 1'b0; readout_tick = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset_done", 32'(done), 32'd0);
        check("reset_rd_en", 32'(rd_en), 32'd0);
        check("reset_rd_addr", 32'(rd_addr), 32'd0);
        check("reset_state", 32'(fsm_state), 32'(IDLE));
        reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);

        // full readout, tick every 6 clocks
        load_fixed();
        run_readout(6, 6, 6, 1'b0, 1'b0, -1, -1);

        // start without mem_valid is ignored
        mem_valid = 1'b0;
        rd0 = rd_cnt;
        cycle(1'b0, 1'b1, 1'b0);
        repeat (2) begin
            repeat (4) cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b1, 1'b0, 1'b0);
        end
        check("nomv_rd_en", 32'(rd_cnt), 32'(rd0));
        check_quiet("nomv");
        check("nomv_state", 32'(fsm_state), 32'(IDLE));
        run_readout(5, 5, 7, 1'b0, 1'b0, -1, -1);

        // first tick lands in FETCH, then in LOAD (pending path)
        run_readout(1, 4, 6, 1'b0, 1'b0, -1, -1);
        run_readout(2, 4, 6, 1'b0, 1'b0, -1, -1);

        // abort during word 2 pair 1, then fresh start from addr 0
        run_readout(6, 6, 6, 1'b0, 1'b0, 2 * PAIRS + 1, -1);
        run_readout(6, 6, 6, 1'b0, 1'b0, -1, -1);

        // asynchronous reset mid-SHIFT, then a normal readout
        load_random();
        run_readout(4, 4, 8, 1'b0, 1'b0, -1, 5);
        run_readout(3, 4, 8, 1'b0, 1'b0, -1, -1);

        // start pulses during the readout are ignored
        load_fixed();
        run_readout(6, 6, 6, 1'b1, 1'b0, -1, -1);

        // randomized memory images, tick spacing and side stimulus
        repeat (8) begin
            load_random();
            run_readout($urandom_range(1, 8), 4, 9, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), -1, -1);
        end

        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("done_total", 32'(done_cnt), 32'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
